mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit.sv | 114 +++++++++++
 tb/tb_mul_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Iterative 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Radix-2 shift-add on magnitudes with a final sign fixup.
module mul_unit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic [31:0] result_out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      FIXUP = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [1:0]  op_q;
   logic        sign_a;
   logic        sign_b;
   logic [63:0] mcand;
   logic [31:0] mplier;
   logic [63:0] acc;
   logic [5:0]  count;

   logic        a_neg;
   logic        b_neg;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        zero_op;
   logic [63:0] prod;

   // MULHU treats a as unsigned; only MUL/MULH treat b as signed
   assign a_neg   = (op != 2'b11) & operand_a[31];
   assign b_neg   = ~op[1] & operand_b[31];
   assign mag_a   = a_neg ? (~operand_a + 32'd1) : operand_a;
   assign mag_b   = b_neg ? (~operand_b + 32'd1) : operand_b;
   assign zero_op = (operand_a == 32'd0) | (operand_b == 32'd0);
   assign prod    = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE: begin
            state_nx = IDLE;
            if (start) state_nx = zero_op ? DONE : RUN;
         end
         RUN: begin
            state_nx = RUN;
            if (count == 6'd1) state_nx = FIXUP;
         end
         FIXUP:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q       <= 2'b00;
         sign_a     <= 1'b0;
         sign_b     <= 1'b0;
         mcand      <= 64'd0;
         mplier     <= 32'd0;
         acc        <= 64'd0;
         count      <= 6'd0;
         result_out <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q   <= op;
                  sign_a <= a_neg;
                  sign_b <= b_neg;
                  mcand  <= {32'd0, mag_a};
                  mplier <= mag_b;
                  acc    <= 64'd0;
                  count  <= 6'd32;
                  if (zero_op) result_out <= 32'd0;
               end
            end
            RUN: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - 6'd1;
            end
            FIXUP: begin
               result_out <= (op_q == 2'b00) ? prod[31:0] : prod[63:32];
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: vector table, corner sequences,
// and random ops against a wide-arithmetic reference.
module tb_mul_unit;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [31:0] result_out;
   logic        busy;
   logic        done;

   int n_cmp;
   int n_err;
   int n_starts;
   int done_seen;

   mul_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .op         (op),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .result_out (result_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_seen++;
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Product of the operands extended per op, taken as a wide integer
   function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [65:0] ea;
      logic signed [65:0] eb;
      logic signed [65:0] p;
      ea = (o != 2'b11) ? {{34{a[31]}}, a} : {34'd0, a};
      eb = (o <  2'b10) ? {{34{b[31]}}, b} : {34'd0, b};
      p  = ea * eb;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] pick();
      int s;
      s = $urandom_range(0, 15);
      case (s)
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int poke,
                         output logic [31:0] res, output int lat,
                         output int bcyc);
      int cyc;
      cyc  = 0;
      lat  = 0;
      bcyc = 0;
      res  = 32'hDEAD_BEEF;
      @(negedge clk);
      op        = o;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      n_starts++;
      do begin
         @(negedge clk);
         cyc++;
         if (busy) bcyc++;
         if (done && lat == 0) begin
            lat = cyc;
            res = result_out;
         end
         if (cyc == poke) begin
            op        = 2'b00;
            operand_a = 32'd7;
            operand_b = 32'd6;
            start     = 1'b1;
         end else begin
            start = 1'b0;
         end
      end while (busy && cyc < 100);
      start = 1'b0;
      if (cyc >= 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL run_op_timeout: busy still %0b after %0d cycles",
                  busy, cyc);
      end
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      int          bcyc;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  o;
      int          exl;

      n_cmp     = 0;
      n_err     = 0;
      n_starts  = 0;
      done_seen = 0;
      reset_n   = 1'b0;
      start     = 1'b1;
      op        = 2'b00;
      operand_a = 32'd3;
      operand_b = 32'd4;

      vt[0]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      vt[1]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34};
      vt[2]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
      vt[3]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
      vt[4]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
      vt[5]  = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1};
      vt[6]  = '{2'b00, 32'd7,         32'd6,         32'd42,        34};
      vt[7]  = '{2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34};
      vt[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
      vt[9]  = '{2'b11, 32'h8000_0000, 32'd2,         32'd1,         34};
      vt[10] = '{2'b11, 32'h1234_5678, 32'd0,         32'd0,         1};
      vt[11] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'd0,         34};

      repeat (3) @(negedge clk);
      chk("reset_result", result_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      start   = 1'b0;
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, -1, res, lat, bcyc);
         chk($sformatf("vec%0d_result", i), res, vt[i].exp);
         chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
         chk($sformatf("vec%0d_busy_cycles", i), bcyc, vt[i].lat);
      end

      // second start while busy must be ignored
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, res, lat, bcyc);
      chk("busy_start_result", res, 32'hFFFF_FFFE);
      chk("busy_start_latency", lat, 34);
      repeat (2) @(negedge clk);
      chk("busy_start_no_restart", busy, 0);

      // start held high through DONE is taken in the first IDLE cycle
      @(negedge clk);
      op        = 2'b00;
      operand_a = 32'd0;
      operand_b = 32'd9;
      start     = 1'b1;
      n_starts += 2;
      @(negedge clk);
      chk("held_fast_done", done, 1);
      operand_a = 32'd4;
      operand_b = 32'd5;
      @(negedge clk);
      chk("held_idle_gap", busy, 0);
      @(negedge clk);
      chk("held_accept", busy, 1);
      start = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("held_done", done, 1);
      chk("held_result", result_out, 32'd20);
      @(negedge clk);

      // async reset mid-RUN
      op        = 2'b00;
      operand_a = 32'h1234;
      operand_b = 32'h5678;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrun_reset_busy", busy, 0);
      chk("midrun_reset_result", result_out, 0);
      chk("midrun_reset_done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_op(2'b00, 32'd7, 32'd6, -1, res, lat, bcyc);
      chk("post_reset_mul", res, 32'd42);
      chk("post_reset_latency", lat, 34);

      for (int i = 0; i < 1500; i++) begin
         o   = 2'($urandom_range(0, 3));
         a   = pick();
         b   = pick();
         exl = (a == 0 || b == 0) ? 1 : 34;
         run_op(o, a, b, -1, res, lat, bcyc);
         chk($sformatf("rand%0d_op%0d_%h_%h", i, o, a, b), res,
             ref_mul(o, a, b));
         chk($sformatf("rand%0d_latency", i), lat, exl);
      end

      repeat (3) @(negedge clk);
      chk("done_vs_accepted_starts", done_seen, n_starts);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
